// File: rtl/pcm1702_receiver_if.sv
// Serial-in / parallel-out bundle for the PCM1702 receiver.
// master drives the 3-wire stream and ready; slave is the receiver.
interface pcm1702_receiver_if #(
  parameter int DATA_W = 20
);
  logic                     bck_in;
  logic                     data_in;
  logic                     le_in;
  logic signed [DATA_W-1:0] sample_out;
  logic                     sample_valid;
  logic                     sample_ready;
  logic                     frame_err;
  logic                     overflow;
  logic                     timeout;

  modport master (
    output bck_in, data_in, le_in, sample_ready,
    input  sample_out, sample_valid, frame_err, overflow, timeout
  );

  modport slave (
    input  bck_in, data_in, le_in, sample_ready,
    output sample_out, sample_valid, frame_err, overflow, timeout
  );
endinterface

// File: rtl/pcm1702_receiver.sv
// PCM1702 3-wire (BCK/DATA/LE) deserializer, oversampled in the clk domain.
// Optional stalled-bit-clock abort enabled by defining PCM_RX_TIMEOUT_EN.
module pcm1702_receiver #(
  parameter int DATA_W         = 20,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  pcm1702_receiver_if.slave   bus
);

  if (SYNC_STAGES < 2 || DATA_W < 2 || DATA_W > 31 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("pcm1702_receiver: illegal parameter value");
  end

  localparam logic [4:0] CNT_WORD = 5'(DATA_W);
  localparam logic [4:0] CNT_MAX  = 5'd31;

  typedef enum logic [2:0] {IDLE, ARMED, SHIFT, LATCH, DONE} state_t;

  state_t                 state, nxt;
  logic [SYNC_STAGES-1:0] bck_sync, data_sync, le_sync;
  logic                   bck_d, le_d;
  logic                   bck_s, data_s, le_s;
  logic                   bck_rise, le_fall;
  logic [DATA_W-1:0]      shreg;
  logic [4:0]             bit_cnt;
  logic                   load_pend;
  logic                   shift_en, cnt_clr, load_ok, err;
  logic                   tmo_hit;

  // bck and data share one synchronizer depth so each sampled bit lines up with its edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      bck_sync  <= '0;
      data_sync <= '0;
      le_sync   <= '1;
      bck_d     <= 1'b0;
      le_d      <= 1'b1;
    end else begin
      bck_sync  <= {bck_sync[SYNC_STAGES-2:0], bus.bck_in};
      data_sync <= {data_sync[SYNC_STAGES-2:0], bus.data_in};
      le_sync   <= {le_sync[SYNC_STAGES-2:0], bus.le_in};
      bck_d     <= bck_s;
      le_d      <= le_s;
    end
  end

  assign bck_s    = bck_sync[SYNC_STAGES-1];
  assign data_s   = data_sync[SYNC_STAGES-1];
  assign le_s     = le_sync[SYNC_STAGES-1];
  assign bck_rise = bck_s & ~bck_d;
  assign le_fall  = ~le_s & le_d;

`ifdef PCM_RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] tmo_cnt;
  logic             bck_edge, waiting;

  assign bck_edge = bck_s ^ bck_d;
  assign waiting  = (state == ARMED) || (state == SHIFT);
  assign tmo_hit  = waiting && !bck_edge && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst || !waiting || bck_edge || tmo_hit) tmo_cnt <= '0;
    else                                         tmo_cnt <= tmo_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) bus.timeout <= 1'b0;
    else      bus.timeout <= tmo_hit;
  end
`else
  assign tmo_hit     = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (le_fall)                 nxt = DONE;
             else if (le_s && !bck_rise)  nxt = ARMED;
      ARMED: if (tmo_hit)                 nxt = IDLE;
             else if (bck_rise)           nxt = le_fall ? LATCH : SHIFT;
             else if (le_fall)            nxt = DONE;
      SHIFT: if (tmo_hit)                 nxt = IDLE;
             else if (le_fall)            nxt = LATCH;
      LATCH:                              nxt = DONE;
      DONE:  if (le_s)                    nxt = ARMED;
      default:                            nxt = IDLE;
    endcase
  end

  // a bit arriving with the LE edge is shifted first; LATCH sees the full count
  always_comb begin
    shift_en = 1'b0;
    cnt_clr  = 1'b0;
    load_ok  = 1'b0;
    err      = 1'b0;
    case (state)
      IDLE:  err      = le_fall;
      ARMED: begin
        shift_en = bck_rise;
        err      = le_fall && !bck_rise;
        cnt_clr  = tmo_hit;
      end
      SHIFT: begin
        shift_en = bck_rise;
        cnt_clr  = tmo_hit;
      end
      LATCH: begin
        load_ok  = (bit_cnt == CNT_WORD);
        err      = (bit_cnt != CNT_WORD);
      end
      DONE:  cnt_clr  = le_s;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (cnt_clr) begin
      bit_cnt <= '0;
      if (tmo_hit) shreg <= '0;
    end else if (shift_en) begin
      shreg   <= {shreg[DATA_W-2:0], data_s};
      bit_cnt <= (bit_cnt == CNT_MAX) ? CNT_MAX : bit_cnt + 5'd1;
    end
  end

  // shreg is frozen in DONE, so the word is copied out one cycle after LATCH
  always_ff @(posedge clk) begin
    if (!rst) begin
      load_pend        <= 1'b0;
      bus.sample_out   <= '0;
      bus.sample_valid <= 1'b0;
      bus.frame_err    <= 1'b0;
      bus.overflow     <= 1'b0;
    end else begin
      load_pend     <= load_ok;
      bus.frame_err <= err;
      if (load_pend) begin
        bus.sample_out   <= shreg;
        bus.sample_valid <= 1'b1;
        if (bus.sample_valid && !bus.sample_ready) bus.overflow <= 1'b1;
      end else if (bus.sample_valid && bus.sample_ready) begin
        bus.sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pcm1702_receiver.sv
// Directed bench for pcm1702_receiver: serial words in, scoreboard of expected samples out.
module tb_pcm1702_receiver;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_pass = 0, n_total = 0;
  int   fe_cnt = 0, to_cnt = 0, hs_cnt = 0;
  logic [19:0] exp_q[$];

  pcm1702_receiver_if #(.DATA_W(20)) bus ();

  pcm1702_receiver #(.DATA_W(20), .SYNC_STAGES(2), .TIMEOUT_CYCLES(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // scoreboard: pop one expected word per accepted handshake
  always @(negedge clk) begin
    if (rst) begin
      if (bus.frame_err) fe_cnt++;
      if (bus.timeout)   to_cnt++;
      if (bus.sample_valid && bus.sample_ready) begin
        hs_cnt++;
        chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("sample", {12'b0, bus.sample_out}, {12'b0, exp_q.pop_front()});
      end
    end
  end

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk); bus.bck_in = 1'b0; bus.data_in = w[i];
      @(negedge clk);
      @(negedge clk); bus.bck_in = 1'b1;
      @(negedge clk);
    end
    @(negedge clk); bus.bck_in = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int n, input bit push);
    if (push) exp_q.push_back(w[19:0]);
    send_bits(w, n);
    bus.le_in = 1'b0;
    clk_n(6);
    bus.le_in = 1'b1;
    clk_n(8);
  endtask

  initial begin
    int lat, fe0, hs0, seen_at;
    bit got;
    logic [31:0] w;

    bus.bck_in = 1'b0; bus.data_in = 1'b0; bus.le_in = 1'b1; bus.sample_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid",    32'(bus.sample_valid), 32'd0);
    chk("rst_sample",   {12'b0, bus.sample_out}, 32'd0);
    chk("rst_frame",    32'(bus.frame_err), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_timeout",  32'(bus.timeout), 32'd0);
    @(negedge clk); rst = 1'b1;
    clk_n(5);

    // single word with latency measurement from the LE pin edge
    fe0 = fe_cnt;
    exp_q.push_back(20'h80001);
    send_bits(32'h80001, 20);
    bus.le_in = 1'b0;
    lat = 0; got = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.sample_valid) begin got = 1; lat = i; end
    end
    chk("latency", 32'(lat), 32'd5);
    clk_n(6); bus.le_in = 1'b1; clk_n(8);
    chk("frame_err_good", 32'(fe_cnt - fe0), 32'd0);

    // back-to-back words
    hs0 = hs_cnt;
    send_word(32'h7FFFF, 20, 1'b1);
    send_word(32'h12345, 20, 1'b1);
    chk("b2b_handshakes", 32'(hs_cnt - hs0), 32'd2);
    chk("b2b_overflow",   32'(bus.overflow), 32'd0);

    // short and long words
    fe0 = fe_cnt;
    send_word(32'h5A5A5, 19, 1'b0);
    chk("short_frame_err", 32'(fe_cnt - fe0), 32'd1);
    chk("short_no_valid",  32'(bus.sample_valid), 32'd0);
    fe0 = fe_cnt;
    send_word(32'h15A5A5, 21, 1'b0);
    chk("long_frame_err", 32'(fe_cnt - fe0), 32'd1);
    chk("long_no_valid",  32'(bus.sample_valid), 32'd0);

    // overwrite while unconsumed
    @(posedge clk); #1 bus.sample_ready = 1'b0;
    send_word(32'hAAAAA, 20, 1'b0);
    chk("ovf_first_valid",  32'(bus.sample_valid), 32'd1);
    chk("ovf_first_sample", {12'b0, bus.sample_out}, 32'hAAAAA);
    chk("ovf_first_flag",   32'(bus.overflow), 32'd0);
    send_word(32'h55555, 20, 1'b1);
    chk("ovf_second_sample", {12'b0, bus.sample_out}, 32'h55555);
    chk("ovf_set",           32'(bus.overflow), 32'd1);
    @(posedge clk); #1 bus.sample_ready = 1'b1;
    clk_n(3);
    chk("ovf_valid_drop", 32'(bus.sample_valid), 32'd0);
    chk("ovf_sticky",     32'(bus.overflow), 32'd1);

    // reset mid-word
    fe0 = fe_cnt;
    w = 32'hFFFFF;
    send_bits(w >> 10, 10);
    rst = 1'b0;
    clk_n(3);
    chk("midrst_valid",    32'(bus.sample_valid), 32'd0);
    chk("midrst_overflow", 32'(bus.overflow), 32'd0);
    rst = 1'b1;
    clk_n(5);
    send_word(32'h0F0F0, 20, 1'b1);
    chk("midrst_frame_err", 32'(fe_cnt - fe0), 32'd0);
    chk("midrst_queue",     32'(exp_q.size()), 32'd0);

    // bit clock stall after 5 bits
    w = 32'h3C3C3;
    send_bits(w >> 15, 5);
`ifdef PCM_RX_TIMEOUT_EN
    seen_at = 0;
    for (int i = 1; i <= 80 && seen_at == 0; i++) begin
      @(negedge clk);
      if (bus.timeout) seen_at = i;
    end
    chk("timeout_seen",   32'(seen_at >= 62 && seen_at <= 72), 32'd1);
    @(negedge clk);
    chk("timeout_pulse1", 32'(bus.timeout), 32'd0);
    clk_n(4);
    send_word(w, 20, 1'b1);
`else
    seen_at = to_cnt;
    clk_n(70);
    chk("no_timeout", 32'(to_cnt - seen_at), 32'd0);
    exp_q.push_back(w[19:0]);
    send_bits(w, 15);
    bus.le_in = 1'b0; clk_n(6); bus.le_in = 1'b1; clk_n(8);
`endif
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pcm1702_receiver.md
Name: pcm1702_receiver

Overview:
Deserializer for the 3-wire PCM1702 sample stream (BCK, DATA, LE) that our DAC-side serializer produces. Recovers each 20-bit two's-complement sample MSB-first and presents it on a parallel valid/ready port. Used for loopback verification of the interpolation output path on-chip and as an input port for external serial sources. Runs entirely in the system clock domain; the bit clock is oversampled, not used as a clock.

Parameters:
DATA_W, 20, sample width in bits; expected bit count per word
SYNC_STAGES, 2, synchronizer depth on bck_in/data_in/le_in (min 2)
TIMEOUT_CYCLES, 64, clk cycles without a BCK edge before abort (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (0 = reset)
bck_in  in  1  serial bit clock from transmitter, at most clk/4
data_in  in  1  serial data, MSB first
le_in  in  1  latch enable, active-low word strobe
sample_out  out  DATA_W  recovered sample, signed
sample_valid  out  1  sample_out holds an unconsumed word
sample_ready  in  1  consumer accepts when valid && ready
frame_err  out  1  one-cycle pulse: word latched with bit count != DATA_W
overflow  out  1  sticky: new word arrived while previous unconsumed
timeout  out  1  one-cycle pulse: bit clock stalled mid-word

Behaviour:
- Reset (rst=0 at posedge clk): sample_out=0, sample_valid=0, frame_err=0, overflow=0, timeout=0, bit_cnt=0, shift reg=0, state IDLE, synchronizers cleared to bck=0, le=1.
- All three inputs pass through SYNC_STAGES flops; bck and data share identical latency. An extra flop on synced bck/le gives edge detects.
- data bit sampled on the clk cycle a synced bck rising edge is detected: shreg <= {shreg[DATA_W-2:0], data_s}; bit_cnt increments and saturates at 31.
- FSM:
  IDLE: wait for le_s=1 with no bck edge pending -> ARMED.
  ARMED: first bck rising edge -> SHIFT, capturing that bit with bit_cnt=1.
  SHIFT: capture bits; le_s falling edge -> LATCH.
  LATCH (1 cycle): if bit_cnt==DATA_W load sample_out<=shreg, else pulse frame_err and load nothing -> DONE.
  DONE: wait le_s=1 -> ARMED, clearing bit_cnt.
- A bck rising edge in the same cycle as the le falling edge is captured before latching (shift first, then LATCH next cycle).
- More than DATA_W bits -> bit_cnt>DATA_W -> frame_err, word dropped.
- le falling edge in IDLE or ARMED (no bits) -> frame_err pulse, return to DONE.
- Output handshake: sample_valid set the cycle after LATCH loads. Cleared on valid&&ready unless a new load occurs in that same cycle; then valid stays 1 with new data and overflow is not set.
- Load while valid=1 and not accepted that cycle: overwrite sample_out, set overflow. overflow clears only on reset.
- Latency: le falling edge on pins -> sample_valid high after SYNC_STAGES+3 clk cycles.
- Reset mid-word discards partial data; no output pulses during reset.

Optional Feature:
PCM_RX_TIMEOUT_EN: when defined, a counter clears on every synced bck edge and increments in ARMED/SHIFT. Reaching TIMEOUT_CYCLES pulses timeout for 1 cycle, discards shreg/bit_cnt and goes to IDLE. When not defined, the counter is absent, timeout is tied 0, and the FSM waits indefinitely.

Test Plan:
- Drive word 20'h8_0001 at bck=clk/4, 20 rising edges, then LE low -> sample_out=20'h80001, sample_valid after SYNC_STAGES+3 cycles, frame_err=0.
- Back-to-back words 20'h7FFFF, 20'h12345 with sample_ready=1 -> two valid handshakes in order, overflow=0.
- Send 19 bits then LE low -> frame_err single pulse, sample_valid stays 0. Repeat with 21 bits for the same result.
- Hold sample_ready=0 and send 20'hAAAAA then 20'h55555 -> sample_out=20'h55555, overflow=1 stays set; raise ready -> valid drops.
- Assert rst=0 after 10 bits, release, then send a full 20'h0F0F0 -> only 20'h0F0F0 delivered, no frame_err.
- With PCM_RX_TIMEOUT_EN, stop bck for 70 cycles after 5 bits -> timeout pulse at cycle 64 of stall; next full word is received correctly.
